// File: rtl/regfile.sv
// rtl/regfile.sv - architectural register file with two combinational read ports and write bypass
//
// Purpose:
//   Write-back register file holding R0-R7 (0-7), SP (8), IH (9), RA (10), T (11).
//   A single write port commits on the rising clock edge; two independent
//   combinational read ports serve the decode stage, with same-cycle bypass
//   of the value currently being written back.
//
// Ports:
//   clk         in   1       system clock, writes on rising edge
//   rst         in   1       asynchronous reset, active-low
//   wReg_i      in   1       write enable
//   wRegAddr_i  in   ADDR_W  write address
//   wData_i     in   DATA_W  write data
//   re1_i       in   1       read enable, port 1
//   rAddr1_i    in   ADDR_W  read address, port 1
//   rData1_o    out  DATA_W  read data, port 1
//   re2_i       in   1       read enable, port 2
//   rAddr2_i    in   ADDR_W  read address, port 2
//   rData2_o    out  DATA_W  read data, port 2

module regfile #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wReg_i,
   input  logic [ADDR_W-1:0] wRegAddr_i,
   input  logic [DATA_W-1:0] wData_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] rAddr1_i,
   output logic [DATA_W-1:0] rData1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] rAddr2_i,
   output logic [DATA_W-1:0] rData2_o
);

   // One extra bit so the register count itself is representable.
   localparam logic [ADDR_W:0] LP_NUM_REGS = NUM_REGS[ADDR_W:0];

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic w_wr_in_range;
   logic w_wr_en;
   logic w_rd1_in_range;
   logic w_rd2_in_range;
   logic w_byp1;
   logic w_byp2;

   assign w_wr_in_range  = ({1'b0, wRegAddr_i} < LP_NUM_REGS);
   assign w_rd1_in_range = ({1'b0, rAddr1_i}   < LP_NUM_REGS);
   assign w_rd2_in_range = ({1'b0, rAddr2_i}   < LP_NUM_REGS);

   // Out-of-range writes are silently dropped.
   assign w_wr_en = wReg_i & w_wr_in_range;

   // Bypass needs only an address match; an out-of-range write can never
   // reach a read port because out-of-range reads are already forced to zero.
   assign w_byp1 = wReg_i & (wRegAddr_i == rAddr1_i);
   assign w_byp2 = wReg_i & (wRegAddr_i == rAddr2_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[wRegAddr_i] <= wData_i;
      end
   end

   // Port 1: reset, enable and range gate first, then bypass, then storage.
   always_comb begin
      rData1_o = '0;
      if (rst && re1_i && w_rd1_in_range) begin
         if (w_byp1) begin
            rData1_o = wData_i;
         end else begin
            rData1_o = r_regs[rAddr1_i];
         end
      end
   end

   // Port 2: identical priority, fully independent of port 1.
   always_comb begin
      rData2_o = '0;
      if (rst && re2_i && w_rd2_in_range) begin
         if (w_byp2) begin
            rData2_o = wData_i;
         end else begin
            rData2_o = r_regs[rAddr2_i];
         end
      end
   end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile with behavioural model and random stimulus

module tb_regfile;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        wReg_i     = 1'b0;
   logic [3:0]  wRegAddr_i = 4'd0;
   logic [15:0] wData_i    = 16'd0;
   logic        re1_i      = 1'b0;
   logic [3:0]  rAddr1_i   = 4'd0;
   logic [15:0] rData1_o;
   logic        re2_i      = 1'b0;
   logic [3:0]  rAddr2_i   = 4'd0;
   logic [15:0] rData2_o;

   int checks = 0;
   int errors = 0;
   int model [12];

   regfile dut (
      .clk        (clk),
      .rst        (rst),
      .wReg_i     (wReg_i),
      .wRegAddr_i (wRegAddr_i),
      .wData_i    (wData_i),
      .re1_i      (re1_i),
      .rAddr1_i   (rAddr1_i),
      .rData1_o   (rData1_o),
      .re2_i      (re2_i),
      .rAddr2_i   (rAddr2_i),
      .rData2_o   (rData2_o)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 12; i++) model[i] = 0;
   end

   // Architectural state: twelve 16-bit values, cleared by reset, written on an edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 12; i++) model[i] = 0;
      end else if (wReg_i && int'(wRegAddr_i) < 12) begin
         model[int'(wRegAddr_i)] = int'(wData_i);
      end
   end

   function automatic logic [15:0] expect_rd(input logic re, input logic [3:0] addr);
      int a;
      a = int'(addr);
      if (!rst) return 16'h0000;
      if (!re) return 16'h0000;
      if (a >= 12) return 16'h0000;
      if (wReg_i && int'(wRegAddr_i) == a) return wData_i;
      return model[a][15:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison of both ports against the model, mid-cycle.
   always @(negedge clk) begin
      chk("model_port1", rData1_o, expect_rd(re1_i, rAddr1_i));
      chk("model_port2", rData2_o, expect_rd(re2_i, rAddr2_i));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      wReg_i = 1'b1; wRegAddr_i = a; wData_i = d;
      cyc();
      wReg_i = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
      re1_i = 1'b1; rAddr1_i = a1;
      re2_i = 1'b1; rAddr2_i = a2;
      #1;
   endtask

   initial begin
      // Reset held from time zero.
      re1_i = 1'b1; re2_i = 1'b1; rAddr1_i = 4'd0; rAddr2_i = 4'd1;
      cyc();
      chk("reset_p1", rData1_o, 16'h0000);
      chk("reset_p2", rData2_o, 16'h0000);
      #2 rst = 1'b1;
      cyc();

      // Write R3 then drop reset asynchronously mid-cycle.
      wr(4'd3, 16'h1234);
      rd(4'd3, 4'd3);
      chk("r3_before_reset", rData1_o, 16'h1234);
      #1 rst = 1'b0;
      #1;
      chk("r3_in_reset_p1", rData1_o, 16'h0000);
      chk("r3_in_reset_p2", rData2_o, 16'h0000);
      // Write presented during reset must be discarded.
      wReg_i = 1'b1; wRegAddr_i = 4'd3; wData_i = 16'h5555;
      cyc();
      wReg_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("r3_after_reset", rData1_o, 16'h0000);
      cyc();

      // Basic write/read.
      wr(4'd5, 16'hBEEF);
      rd(4'd5, 4'd5);
      chk("r5_p1", rData1_o, 16'hBEEF);
      chk("r5_p2", rData2_o, 16'hBEEF);
      rd(4'd4, 4'd5);
      chk("r4_zero", rData1_o, 16'h0000);

      // Bypass on port 1 while port 2 reads stored R7.
      wReg_i = 1'b1; wRegAddr_i = 4'd2; wData_i = 16'h00A5;
      rd(4'd2, 4'd7);
      chk("bypass_r2", rData1_o, 16'h00A5);
      chk("stored_r7", rData2_o, 16'h0000);
      cyc();
      wReg_i = 1'b0;
      rd(4'd2, 4'd2);
      chk("r2_stored", rData1_o, 16'h00A5);

      // Special registers and unimplemented addresses.
      wr(4'd8, 16'hBF00);
      wr(4'd11, 16'h0001);
      rd(4'd8, 4'd11);
      chk("sp", rData1_o, 16'hBF00);
      chk("t", rData2_o, 16'h0001);
      wReg_i = 1'b1; wRegAddr_i = 4'd13; wData_i = 16'hFFFF;
      rd(4'd13, 4'd8);
      chk("oor_no_bypass", rData1_o, 16'h0000);
      cyc();
      wReg_i = 1'b0;
      rd(4'd13, 4'd5);
      chk("oor_read", rData1_o, 16'h0000);
      chk("oor_r5_kept", rData2_o, 16'hBEEF);
      for (int i = 0; i < 12; i++) begin
         rd(4'(i), 4'(i));
         chk("oor_regs_kept", rData1_o, model[i][15:0]);
      end

      // Both ports bypassing the same special register.
      wReg_i = 1'b1; wRegAddr_i = 4'd9; wData_i = 16'h7E57;
      rd(4'd9, 4'd9);
      chk("ih_bypass_p1", rData1_o, 16'h7E57);
      chk("ih_bypass_p2", rData2_o, 16'h7E57);
      cyc();
      wReg_i = 1'b0;

      // Read-enable gating, including during a matching bypass write.
      rd(4'd5, 4'd5);
      re1_i = 1'b0;
      #1;
      chk("re1_off", rData1_o, 16'h0000);
      wReg_i = 1'b1; wRegAddr_i = 4'd5; wData_i = 16'h2222;
      #1;
      chk("re1_off_bypass", rData1_o, 16'h0000);
      chk("re2_bypass", rData2_o, 16'h2222);
      wReg_i = 1'b0;
      #1;

      // Write-disable for three cycles.
      wRegAddr_i = 4'd5; wData_i = 16'h1111;
      rd(4'd5, 4'd5);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wdis_r5", rData2_o, 16'hBEEF);
      end

      // Back-to-back writes to one address: last edge wins, second cycle bypasses.
      wReg_i = 1'b1; wRegAddr_i = 4'd0; wData_i = 16'h0001;
      cyc();
      wData_i = 16'h0002;
      rd(4'd0, 4'd0);
      chk("b2b_bypass", rData1_o, 16'h0002);
      cyc();
      wReg_i = 1'b0;
      #1;
      chk("b2b_final", rData1_o, 16'h0002);

      // Randomized traffic with occasional asynchronous reset pulses.
      for (int n = 0; n < 400; n++) begin
         wReg_i     = 1'($urandom_range(0, 1));
         wRegAddr_i = 4'($urandom_range(0, 15));
         wData_i    = 16'($urandom);
         re1_i      = ($urandom_range(0, 7) != 0);
         re2_i      = ($urandom_range(0, 7) != 0);
         rAddr1_i   = ($urandom_range(0, 3) == 0) ? wRegAddr_i : 4'($urandom_range(0, 15));
         rAddr2_i   = ($urandom_range(0, 3) == 0) ? wRegAddr_i : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) begin
            #2 rst = 1'b0;
            #4 rst = 1'b1;
            #1;
         end
         cyc();
      end

      wReg_i = 1'b0;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
